frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Frame-level scheduler between the exposure engine and the row readout engine. Issues exposure start, converts the exposure-done pulse into a readout trigger, and gates readout on downstream FIFO space. Owns the shared row-address bus. Optionally overlaps exposure of frame N+1 with readout of frame N, and counts frames for a bounded or continuous capture.

## Interface
- ROW_W, 8, row address width
- FRAME_W, 16, frame counter / num_frames width
- ACK_TO, 15, cycles allowed for ro_busy to rise after ro_trigger
- CLK  in  1  system clock (single domain)
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  1-cycle pulse; begins capture (honoured only in IDLE)
- stop  in  1  1-cycle pulse; requests end of capture
- num_frames  in  FRAME_W  frames per capture, sampled on start; 0 = continuous
- overlap  in  1  sampled on start; 1 = expose next frame during readout
- fifo_almost_full  in  1  downstream FIFO cannot accept a frame
- exp_trigger  in  1  1-cycle pulse from exposure engine: exposure complete
- ro_busy  in  1  readout engine active
- ROWADD_EXP  in  ROW_W  row address from exposure engine
- ROWADD_RO  in  ROW_W  row address from readout engine
- ROWADD  out  ROW_W  registered shared row address to sensor
- exp_start  out  1  level; exposure engine may run while high
- ro_trigger  out  1  1-cycle pulse; start readout
- seq_busy  out  1  high in any state but IDLE
- frame_cnt  out  FRAME_W  frames completed in this capture
- frame_done  out  1  1-cycle pulse per completed readout
- overrun  out  1  sticky; exposure completed while one was already pending
- ack_err  out  1  sticky; readout did not acknowledge within ACK_TO

## Operation
- States: IDLE, EXPOSE, ARM_RO, RO_ACK, READOUT, NEXT.
- IDLE: exp_start=0. start (without stop in same cycle) -> EXPOSE; latch num_frames, overlap; clear frame_cnt, overrun, ack_err, exp_pend, stop_req.
- EXPOSE: exp_start=1. exp_trigger -> ARM_RO. stop -> IDLE immediately (no readout).
- ARM_RO: exp_start=0. When ro_busy=0 and fifo_almost_full=0: ro_trigger=1 for one cycle -> RO_ACK. Waits indefinitely otherwise.
- RO_ACK: ro_busy=1 -> READOUT. ACK_TO cycles without it -> set ack_err -> IDLE.
- READOUT: on ro_busy falling (observed 0): frame_cnt+1, frame_done=1 -> NEXT. exp_start=1 here only if overlap=1, stop_req=0 and frames remain after the current one (num_frames=0 or frame_cnt+1<num_frames).
- In READOUT with overlap: exp_trigger sets exp_pend; exp_trigger while exp_pend=1 sets overrun and is dropped.
- NEXT (one cycle): stop_req or (num_frames!=0 and frame_cnt==num_frames) -> IDLE; else exp_pend=1 -> clear exp_pend, ARM_RO; else -> EXPOSE.
- stop outside IDLE/EXPOSE sets stop_req; current readout completes, then IDLE; a pending exposure is discarded.
- start outside IDLE ignored. start and stop in same cycle in IDLE: stay IDLE.
- frame_cnt wraps 2^FRAME_W-1 -> 0 in continuous mode; terminal compare only when num_frames!=0.
- ROWADD <= ro_busy ? ROWADD_RO : ROWADD_EXP every cycle, regardless of state.

## Timing
- Reset: all outputs 0, state IDLE, exp_pend/stop_req 0.
- start at cycle t -> seq_busy and exp_start high at t+1.
- exp_trigger at t (FIFO free, ro_busy=0) -> state ARM_RO at t+1, ro_trigger at t+1 (combinational in ARM_RO on qualifying inputs, registered output allowed only if pulse stays exactly 1 cycle and at t+2 max).
- ro_busy low at t in READOUT -> frame_done and frame_cnt update at t+1; next exp_start at t+2.
- ROWADD latency: 1 cycle from input/select change.
- ack_err: raised exactly ACK_TO cycles after ro_trigger if ro_busy never seen high.
- rst_n assertion mid-frame: all outputs 0 asynchronously; no further ro_trigger.

## Test plan
- num_frames=3, overlap=0, readout model busy 100 cycles -> exactly 3 ro_trigger pulses, 3 frame_done, frame_cnt=3, seq_busy falls after third readout.
- overlap=1, num_frames=2, exp_trigger during first readout -> second ro_trigger follows first ro_busy fall within 3 cycles, no exp_start during second readout.
- fifo_almost_full high 500 cycles at exp_trigger -> no ro_trigger until it falls, then one pulse next cycle.
- overlap=1, two exp_trigger pulses during one readout -> overrun=1, only one extra readout.
- stop during EXPOSE -> IDLE next cycle, no ro_trigger; stop during READOUT -> frame_done once, then IDLE.
- ro_busy never rises -> ack_err=1 at ACK_TO=15 cycles after ro_trigger, state IDLE; ROWADD follows ROWADD_RO only while ro_busy=1.

Source files
------------

// File: rtl/frame_sequencer.sv
// Frame scheduler: exposure start, readout trigger on exposure done, FIFO-gated readout, frame counting.
// ro_trigger is combinational in ARM_RO (same cycle as qualifying inputs); waits on fifo_almost_full/ro_busy.
module frame_sequencer #(
  parameter int ROW_W   = 8,
  parameter int FRAME_W = 16,
  parameter int ACK_TO  = 15
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [FRAME_W-1:0] num_frames,
  input  logic               overlap,
  input  logic               fifo_almost_full,
  input  logic               exp_trigger,
  input  logic               ro_busy,
  input  logic [ROW_W-1:0]   ROWADD_EXP,
  input  logic [ROW_W-1:0]   ROWADD_RO,
  output logic [ROW_W-1:0]   ROWADD,
  output logic               exp_start,
  output logic               ro_trigger,
  output logic               seq_busy,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               frame_done,
  output logic               overrun,
  output logic               ack_err
);

  typedef enum logic [2:0] {IDLE, EXPOSE, ARM_RO, RO_ACK, READOUT, NEXT} state_t;

  localparam int ACK_CW = (ACK_TO > 2) ? $clog2(ACK_TO) : 1;
  localparam logic [ACK_CW-1:0] ACK_LAST = ACK_CW'(ACK_TO - 2);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] nf_q, nf_d;
  logic               ovl_q, ovl_d;
  logic [FRAME_W-1:0] cnt_q, cnt_d;
  logic               overrun_q, overrun_d;
  logic               ack_err_q, ack_err_d;
  logic               pend_q, pend_d;
  logic               stop_req_q, stop_req_d;
  logic [ACK_CW-1:0]  ack_cnt_q, ack_cnt_d;
  logic               done_q, done_d;
  logic [ROW_W-1:0]   rowadd_q;
  logic               exp_start_c, ro_trig_c;
  logic [FRAME_W:0]   cnt_inc;
  logic               frames_remain, last_frame;

  // One bit wider so the remaining-frames compare cannot wrap at the top count.
  assign cnt_inc       = {1'b0, cnt_q} + {{FRAME_W{1'b0}}, 1'b1};
  assign frames_remain = (nf_q == '0) || (cnt_inc < {1'b0, nf_q});
  assign last_frame    = (nf_q != '0) && (cnt_q == nf_q);

  always_comb begin
    state_d     = state_q;
    nf_d        = nf_q;
    ovl_d       = ovl_q;
    cnt_d       = cnt_q;
    overrun_d   = overrun_q;
    ack_err_d   = ack_err_q;
    pend_d      = pend_q;
    stop_req_d  = stop_req_q;
    ack_cnt_d   = ack_cnt_q;
    done_d      = 1'b0;
    exp_start_c = 1'b0;
    ro_trig_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d    = EXPOSE;
          nf_d       = num_frames;
          ovl_d      = overlap;
          cnt_d      = '0;
          overrun_d  = 1'b0;
          ack_err_d  = 1'b0;
          pend_d     = 1'b0;
          stop_req_d = 1'b0;
        end
      end
      EXPOSE: begin
        exp_start_c = 1'b1;
        if (stop)             state_d = IDLE;
        else if (exp_trigger) state_d = ARM_RO;
      end
      ARM_RO: begin
        if (stop) stop_req_d = 1'b1;
        if (!ro_busy && !fifo_almost_full) begin
          ro_trig_c = 1'b1;
          ack_cnt_d = '0;
          state_d   = RO_ACK;
        end
      end
      RO_ACK: begin
        if (stop) stop_req_d = 1'b1;
        if (ro_busy) begin
          state_d = READOUT;
        end else if (ack_cnt_q == ACK_LAST) begin
          ack_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_CW'(1);
        end
      end
      READOUT: begin
        if (stop) stop_req_d = 1'b1;
        exp_start_c = ovl_q && !stop_req_q && frames_remain;
        // A second completed exposure has nowhere to go; flag it and drop it.
        if (ovl_q && exp_trigger) begin
          if (pend_q) overrun_d = 1'b1;
          else        pend_d    = 1'b1;
        end
        if (!ro_busy) begin
          cnt_d   = cnt_inc[FRAME_W-1:0];
          done_d  = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (stop_req_q || stop || last_frame) begin
          state_d    = IDLE;
          pend_d     = 1'b0;
          stop_req_d = 1'b0;
        end else if (pend_q) begin
          pend_d  = 1'b0;
          state_d = ARM_RO;
        end else begin
          state_d = EXPOSE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      nf_q       <= '0;
      ovl_q      <= 1'b0;
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
      ack_err_q  <= 1'b0;
      pend_q     <= 1'b0;
      stop_req_q <= 1'b0;
      ack_cnt_q  <= '0;
      done_q     <= 1'b0;
      rowadd_q   <= '0;
    end else begin
      state_q    <= state_d;
      nf_q       <= nf_d;
      ovl_q      <= ovl_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
      ack_err_q  <= ack_err_d;
      pend_q     <= pend_d;
      stop_req_q <= stop_req_d;
      ack_cnt_q  <= ack_cnt_d;
      done_q     <= done_d;
      rowadd_q   <= ro_busy ? ROWADD_RO : ROWADD_EXP;
    end
  end

  assign ROWADD     = rowadd_q;
  assign exp_start  = exp_start_c;
  assign ro_trigger = ro_trig_c;
  assign seq_busy   = (state_q != IDLE);
  assign frame_cnt  = cnt_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;
  assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: inputs change 1 time unit after the rising edge, outputs checked at the falling edge.
module tb_frame_sequencer;
  localparam int ROW_W   = 8;
  localparam int FRAME_W = 16;
  localparam int ACK_TO  = 15;

  logic               CLK = 1'b0;
  logic               rst_n;
  logic               start, stop, overlap, fifo_almost_full, exp_trigger, ro_busy;
  logic [FRAME_W-1:0] num_frames;
  logic [ROW_W-1:0]   rowadd_exp, rowadd_ro, rowadd;
  logic               exp_start, ro_trigger, seq_busy, frame_done, overrun, ack_err;
  logic [FRAME_W-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int n_trig = 0;
  int n_done = 0;
  int n_exp_ro = 0;
  int b_t, b_d, b_e;

  always #5 CLK = ~CLK;

  frame_sequencer #(.ROW_W(ROW_W), .FRAME_W(FRAME_W), .ACK_TO(ACK_TO)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .stop(stop), .num_frames(num_frames),
    .overlap(overlap), .fifo_almost_full(fifo_almost_full), .exp_trigger(exp_trigger),
    .ro_busy(ro_busy), .ROWADD_EXP(rowadd_exp), .ROWADD_RO(rowadd_ro), .ROWADD(rowadd),
    .exp_start(exp_start), .ro_trigger(ro_trigger), .seq_busy(seq_busy), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .overrun(overrun), .ack_err(ack_err)
  );

  always @(posedge CLK) begin
    if (ro_trigger)           n_trig++;
    if (frame_done)           n_done++;
    if (exp_start && ro_busy) n_exp_ro++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic half();
    #4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_start(input logic [FRAME_W-1:0] nf, input logic ov);
    num_frames = nf;
    overlap    = ov;
    start      = 1'b1;
    tick();
    start = 1'b0;
    half();
    chk("start_busy", {31'd0, seq_busy}, 32'd1);
    chk("start_exp", {31'd0, exp_start}, 32'd1);
  endtask

  // Called during an EXPOSE cycle; returns just after the edge two cycles past readout end.
  task automatic do_frame(input int busy_len, input string tag);
    exp_trigger = 1'b1;
    tick();
    exp_trigger = 1'b0;
    half();
    chk({tag, "_trig"}, {31'd0, ro_trigger}, 32'd1);
    tick();
    ro_busy = 1'b1;
    repeat (busy_len) tick();
    ro_busy = 1'b0;
    tick();
    half();
    chk({tag, "_done"}, {31'd0, frame_done}, 32'd1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; overlap = 1'b0; fifo_almost_full = 1'b0;
    exp_trigger = 1'b0; ro_busy = 1'b0; num_frames = '0; rowadd_exp = '0; rowadd_ro = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_outs", {rowadd, exp_start, ro_trigger, seq_busy, frame_done, overrun, ack_err}, 32'd0);
    chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    rst_n = 1'b1;

    // Row address mux, one-cycle latency
    rowadd_exp = 8'h11; rowadd_ro = 8'h22;
    half();
    chk("row_pre", {24'd0, rowadd}, 32'h00);
    tick(); half();
    chk("row_exp", {24'd0, rowadd}, 32'h11);
    ro_busy = 1'b1;
    tick(); half();
    chk("row_ro", {24'd0, rowadd}, 32'h22);
    ro_busy = 1'b0;
    tick(); half();
    chk("row_back", {24'd0, rowadd}, 32'h11);

    // start with stop in the same cycle is ignored
    tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    half();
    chk("startstop_idle", {31'd0, seq_busy}, 32'd0);

    // Bounded capture, no overlap
    tick();
    b_t = n_trig; b_d = n_done; b_e = n_exp_ro;
    do_start(16'd3, 1'b0);
    do_frame(100, "s1f1");
    half();
    chk("s1_cnt1", {16'd0, frame_cnt}, 32'd1);
    chk("s1_exp2", {31'd0, exp_start}, 32'd1);
    do_frame(100, "s1f2");
    half();
    chk("s1_exp3", {31'd0, exp_start}, 32'd1);
    do_frame(100, "s1f3");
    half();
    chk("s1_idle", {31'd0, seq_busy}, 32'd0);
    chk("s1_cnt3", {16'd0, frame_cnt}, 32'd3);
    chk("s1_ntrig", n_trig - b_t, 32'd3);
    chk("s1_ndone", n_done - b_d, 32'd3);
    chk("s1_noexp_ro", n_exp_ro - b_e, 32'd0);

    // Overlap, two frames
    tick();
    do_start(16'd2, 1'b1);
    exp_trigger = 1'b1;
    tick();
    exp_trigger = 1'b0;
    half();
    chk("s2_trig1", {31'd0, ro_trigger}, 32'd1);
    tick();
    ro_busy = 1'b1;
    tick(); half();
    chk("s2_exp_ro1", {31'd0, exp_start}, 32'd1);
    tick();
    exp_trigger = 1'b1;
    tick();
    exp_trigger = 1'b0;
    repeat (10) tick();
    ro_busy = 1'b0;
    tick(); half();
    chk("s2_done1", {31'd0, frame_done}, 32'd1);
    tick(); half();
    chk("s2_trig2", {31'd0, ro_trigger}, 32'd1);
    tick();
    ro_busy = 1'b1;
    tick(); half();
    chk("s2_exp_ro2", {31'd0, exp_start}, 32'd0);
    repeat (5) tick();
    ro_busy = 1'b0;
    tick(); tick(); half();
    chk("s2_idle", {31'd0, seq_busy}, 32'd0);
    chk("s2_cnt", {16'd0, frame_cnt}, 32'd2);

    // FIFO backpressure holds off the readout trigger
    tick();
    do_start(16'd1, 1'b0);
    fifo_almost_full = 1'b1;
    exp_trigger = 1'b1;
    tick();
    exp_trigger = 1'b0;
    b_t = n_trig;
    repeat (500) tick();
    half();
    chk("s3_held", {31'd0, ro_trigger}, 32'd0);
    chk("s3_held_cnt", n_trig - b_t, 32'd0);
    tick();
    fifo_almost_full = 1'b0;
    half();
    chk("s3_release", {31'd0, ro_trigger}, 32'd1);
    tick(); half();
    chk("s3_one_pulse", {31'd0, ro_trigger}, 32'd0);
    chk("s3_cnt_trig", n_trig - b_t, 32'd1);
    ro_busy = 1'b1;
    repeat (5) tick();
    ro_busy = 1'b0;
    tick(); half();
    chk("s3_done", {31'd0, frame_done}, 32'd1);
    tick(); half();
    chk("s3_idle", {31'd0, seq_busy}, 32'd0);

    // Overrun, single extra readout, then stop during EXPOSE
    tick();
    do_start(16'd3, 1'b1);
    b_t = n_trig;
    exp_trigger = 1'b1;
    tick();
    exp_trigger = 1'b0;
    half();
    chk("s4_trig1", {31'd0, ro_trigger}, 32'd1);
    tick();
    ro_busy = 1'b1;
    tick();
    exp_trigger = 1'b1;
    tick();
    exp_trigger = 1'b0;
    half();
    chk("s4_no_overrun", {31'd0, overrun}, 32'd0);
    tick(); tick();
    exp_trigger = 1'b1;
    tick();
    exp_trigger = 1'b0;
    half();
    chk("s4_overrun", {31'd0, overrun}, 32'd1);
    repeat (5) tick();
    ro_busy = 1'b0;
    tick(); tick(); half();
    chk("s4_trig2", {31'd0, ro_trigger}, 32'd1);
    tick();
    ro_busy = 1'b1;
    repeat (5) tick();
    ro_busy = 1'b0;
    tick(); tick(); half();
    chk("s4_expose", {31'd0, exp_start}, 32'd1);
    chk("s4_no_trig3", {31'd0, ro_trigger}, 32'd0);
    chk("s4_ntrig", n_trig - b_t, 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    half();
    chk("s4_stop_idle", {31'd0, seq_busy}, 32'd0);
    chk("s4_stop_exp", {31'd0, exp_start}, 32'd0);
    repeat (3) tick();
    chk("s4_ntrig_after", n_trig - b_t, 32'd2);
    chk("s4_cnt", {16'd0, frame_cnt}, 32'd2);

    // Stop during READOUT in continuous overlap mode
    do_start(16'd0, 1'b1);
    exp_trigger = 1'b1;
    tick();
    exp_trigger = 1'b0;
    tick();
    ro_busy = 1'b1;
    tick(); half();
    chk("s5_exp_ro", {31'd0, exp_start}, 32'd1);
    b_d = n_done;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    half();
    chk("s5_exp_off", {31'd0, exp_start}, 32'd0);
    chk("s5_still_busy", {31'd0, seq_busy}, 32'd1);
    repeat (4) tick();
    ro_busy = 1'b0;
    tick(); half();
    chk("s5_done", {31'd0, frame_done}, 32'd1);
    tick(); half();
    chk("s5_idle", {31'd0, seq_busy}, 32'd0);
    chk("s5_ndone", n_done - b_d, 32'd1);
    chk("s5_cnt", {16'd0, frame_cnt}, 32'd1);

    // Readout never acknowledges
    tick();
    do_start(16'd1, 1'b0);
    exp_trigger = 1'b1;
    tick();
    exp_trigger = 1'b0;
    half();
    chk("s6_trig", {31'd0, ro_trigger}, 32'd1);
    repeat (5) tick();
    half();
    chk("s6_row_exp", {24'd0, rowadd}, 32'h11);
    repeat (ACK_TO - 6) tick();
    half();
    chk("s6_no_err_yet", {31'd0, ack_err}, 32'd0);
    chk("s6_busy_yet", {31'd0, seq_busy}, 32'd1);
    tick(); half();
    chk("s6_ack_err", {31'd0, ack_err}, 32'd1);
    chk("s6_idle", {31'd0, seq_busy}, 32'd0);
    tick(); half();
    chk("s6_no_trig", {31'd0, ro_trigger}, 32'd0);

    // Asynchronous reset mid-frame
    tick();
    do_start(16'd2, 1'b0);
    do_frame(3, "s7f1");
    half();
    exp_trigger = 1'b1;
    tick();
    exp_trigger = 1'b0;
    half();
    chk("s7_trig", {31'd0, ro_trigger}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s7_rst_outs", {rowadd, exp_start, ro_trigger, seq_busy, frame_done, overrun, ack_err}, 32'd0);
    chk("s7_rst_cnt", {16'd0, frame_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    half();
    chk("s7_post_trig", {31'd0, ro_trigger}, 32'd0);
    chk("s7_post_idle", {31'd0, seq_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
